// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the Gray counter family.
package gray_pkg;

  // Widest counter the helpers and the counter support.
  localparam int unsigned MaxWidth = 32;

  typedef logic [MaxWidth-1:0] word_t;

  // Per-edge operation selected by the counter's next-state mux (reset is handled in the flop).
  typedef enum logic [1:0] {
    OpHold,
    OpStep,
    OpLoad
  } op_e;

  // Binary to Gray; valid for any width up to MaxWidth when the upper bits are zero.
  function automatic word_t bin2gray(input word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary as an XOR prefix from the MSB down; zero upper bits leave the result intact.
  function automatic word_t gray2bin(input word_t gray);
    word_t bin;
    logic  acc;
    bin = '0;
    acc = 1'b0;
    for (int i = int'(MaxWidth) - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary converter of configurable width.
module gray_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // XOR prefix from the MSB down: bin[i] is the parity of gray[WIDTH-1:i].
  always_comb begin
    logic acc;
    acc = 1'b0;
    bin = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray_counter_param.sv
// Registered Gray-code counter with enable, direction, synchronous load and wrap/saturate mode.
// A binary register and a Gray register are kept in lock step so both views come straight
// from flops, giving a glitch-free Gray value for sampling in another clock domain.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_count,
  output logic [WIDTH-1:0] bin_count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] One       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ResetBin  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ResetGray = WIDTH'(bin2gray(word_t'(ResetBin)));

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step_bin;
  logic [WIDTH-1:0] step_gray;
  logic             at_max;
  logic             at_min;
  logic             at_limit;
  logic             hold_at_limit;
  op_e              op;

  // The only long path: a WIDTH-deep XOR chain from load_gray into the binary register.
  gray_to_bin #(
    .WIDTH(WIDTH)
  ) u_load_conv (
    .gray(load_gray),
    .bin (load_bin)
  );

  // Decode the operation for this edge; load outranks counting.
  always_comb begin
    op = OpHold;
    if (load) begin
      op = OpLoad;
    end else if (en) begin
      op = OpStep;
    end
  end

  // Boundary detection and the candidate step value in the selected direction.
  always_comb begin
    at_max        = &bin_q;
    at_min        = ~|bin_q;
    at_limit      = up ? at_max : at_min;
    hold_at_limit = SATURATE && at_limit;
    step_bin      = up ? (bin_q + One) : (bin_q - One);
    step_gray     = WIDTH'(bin2gray(word_t'(step_bin)));
  end

  // Next-state mux; tc only flags an enabled step taken from the direction boundary.
  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    tc_d   = 1'b0;
    unique case (op)
      OpLoad: begin
        // Gray register takes the loaded code verbatim, not a re-encoding of load_bin.
        bin_d  = load_bin;
        gray_d = load_gray;
      end
      OpStep: begin
        tc_d = at_limit;
        if (!hold_at_limit) begin
          bin_d  = step_bin;
          gray_d = step_gray;
        end
      end
      OpHold: begin
      end
    endcase
  end

  // State registers with synchronous reset overriding load and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= ResetBin;
      gray_q <= ResetGray;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bin_count  = bin_q;
  assign gray_count = gray_q;
  assign tc         = tc_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Self-checking bench for gray_counter_param: vector table, directed corner sequences, width sweep.
module tb_gray_counter_param;
  import gray_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the three WIDTH=4 instances.
  logic       rst, en, up, load;
  logic [3:0] lg;
  logic [3:0] wg, wb, sg, sb, rg, rb;
  logic       wtc, stc, rtc;

  // Stimulus for the width-sweep instances.
  logic        sw_rst, sw_en, sw_up, sw_load;
  logic [15:0] sw_lg;
  logic [0:0]  g1, b1;
  logic        t1;
  logic [15:0] g16, b16;
  logic        t16;

  int n_checks = 0;
  int n_fail   = 0;

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg),
    .gray_count(wg), .bin_count(wb), .tc(wtc));

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg),
    .gray_count(sg), .bin_count(sb), .tc(stc));

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(5)) u_rv5 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg),
    .gray_count(rg), .bin_count(rb), .tc(rtc));

  gray_counter_param #(.WIDTH(1), .SATURATE(1'b0), .RESET_VALUE(0)) u_w1 (
    .clk(clk), .rst(sw_rst), .en(sw_en), .up(sw_up), .load(sw_load), .load_gray(sw_lg[0:0]),
    .gray_count(g1), .bin_count(b1), .tc(t1));

  gray_counter_param #(.WIDTH(16), .SATURATE(1'b0), .RESET_VALUE(0)) u_w16 (
    .clk(clk), .rst(sw_rst), .en(sw_en), .up(sw_up), .load(sw_load), .load_gray(sw_lg),
    .gray_count(g16), .bin_count(b16), .tc(t16));

  typedef struct {
    logic       rst, en, up, load;
    logic [3:0] lg;
    logic [3:0] g;
    logic [3:0] b;
    logic       tc;
    logic       step;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, e, u, l, input logic [3:0] lgv, gv, bv,
                     input logic t, s);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.lg = lgv;
    v.g = gv; v.b = bv; v.tc = t; v.step = s;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, e, u, l, input logic [3:0] lgv);
    rst = r; en = e; up = u; load = l; lg = lgv;
  endtask

  // Reference model of a wrapping counter, RESET_VALUE=0.
  task automatic model(input int w, inout logic [31:0] b, inout logic t,
                       input logic r, l, e, u, input logic [31:0] lgv);
    logic [31:0] mask;
    logic        lim;
    mask = (w == 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    if (r) begin
      b = 0; t = 1'b0;
    end else if (l) begin
      b = gray2bin(lgv & mask); t = 1'b0;
    end else if (e) begin
      lim = u ? (b == mask) : (b == 0);
      t = lim;
      b = (u ? b + 32'd1 : b - 32'd1) & mask;
    end else begin
      t = 1'b0;
    end
  endtask

  logic [3:0] up_seq [16];

  initial begin
    logic [3:0]  prev;
    logic [31:0] m1, m16, pg1, pg16;
    logic        mt1, mt16;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    sw_rst = 1'b1; sw_en = 1'b0; sw_up = 1'b0; sw_load = 1'b0; sw_lg = '0;

    // Expected Gray codes for binary 1..15 then the wrap to 0.
    up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
               4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    //   rst  en   up   load  lg       gray     bin  tc  step
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, up_seq[i], 4'((i + 1) % 16), (i == 15), 1'b1);
    end
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 4'b1101, 4'd9,  1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'd0,  1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'd15, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1001, 4'd14, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'd14, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'd15, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0,  1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0,  1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lg);
      prev = wg;
      tick();
      check($sformatf("v%0d_gray", i), wg,  vecs[i].g);
      check($sformatf("v%0d_bin", i),  wb,  vecs[i].b);
      check($sformatf("v%0d_tc", i),   wtc, vecs[i].tc);
      if (vecs[i].step) check($sformatf("v%0d_onebit", i), $countones(wg ^ prev), 1);
    end

    // Reset values of the saturating and RESET_VALUE=5 instances.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    check("rv5_reset_bin", rb, 5);
    check("rv5_reset_gray", rg, 4'b0111);
    check("rv5_reset_tc", rtc, 0);
    check("sat_reset_bin", sb, 0);

    // Saturate at all-ones going up, then step down off the limit.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    tick();
    check("sat_load_bin", sb, 15);
    check("sat_load_gray", sg, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
      tick();
      check($sformatf("sat_up%0d_gray", i), sg, 4'b1000);
      check($sformatf("sat_up%0d_tc", i), stc, 1);
      if (i == 0) begin
        check("wrap_from_max_gray", wg, 4'b0000);
        check("wrap_from_max_tc", wtc, 1);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    check("sat_down_gray", sg, 4'b1001);
    check("sat_down_bin", sb, 14);
    check("sat_down_tc", stc, 0);

    // Saturate at zero going down.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      check($sformatf("sat_zero%0d_gray", i), sg, 4'b0000);
      check($sformatf("sat_zero%0d_tc", i), stc, 1);
    end

    // Reset overrides an enabled step from all-ones (tc must stay low).
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    check("rst_over_en_tc", wtc, 0);
    check("rst_over_en_bin", wb, 0);

    // Reset overrides load and count while at bin 6.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);
    tick();
    check("mid_pre_bin", wb, 6);
    check("mid_pre_rv5_bin", rb, 6);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
    tick();
    check("mid_rst_bin", wb, 0);
    check("mid_rst_gray", wg, 4'b0000);
    check("mid_rst_tc", wtc, 0);
    check("mid_rst_rv5_bin", rb, 5);
    check("mid_rst_rv5_gray", rg, 4'b0111);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    check("mid_resume_bin", wb, 1);
    check("mid_resume_gray", wg, 4'b0001);
    check("mid_resume_rv5_gray", rg, 4'b0101);

    // Random width sweep against the reference model.
    sw_rst = 1'b1;
    tick();
    m1 = 0; m16 = 0; mt1 = 1'b0; mt16 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      sw_rst  = ($urandom_range(0, 199) == 0);
      sw_load = ($urandom_range(0, 7) == 0);
      sw_en   = ($urandom_range(0, 3) != 0);
      sw_up   = $urandom_range(0, 1) != 0;
      sw_lg   = 16'($urandom);
      pg1 = 32'(g1);
      pg16 = 32'(g16);
      tick();
      model(1, m1, mt1, sw_rst, sw_load, sw_en, sw_up, 32'(sw_lg[0]));
      model(16, m16, mt16, sw_rst, sw_load, sw_en, sw_up, 32'(sw_lg));
      check("w1_bin", b1, m1);
      check("w1_gray", g1, (!sw_rst && sw_load) ? 32'(sw_lg[0]) : bin2gray(m1));
      check("w1_tc", t1, mt1);
      check("w1_gray_eq_bin", g1, b1);
      check("w16_bin", b16, m16);
      check("w16_gray", g16, (!sw_rst && sw_load) ? 32'(sw_lg) : bin2gray(m16));
      check("w16_tc", t16, mt16);
      check("w16_gray_rel", 32'(g16), bin2gray(32'(b16)));
      if (!sw_rst && !sw_load) begin
        check("w1_hamming_le1", ($countones(32'(g1) ^ pg1) <= 1), 1);
        check("w16_hamming_le1", ($countones(32'(g16) ^ pg16) <= 1), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
